decode_ctrl: RTL and testbench

- Decode-stage controller for the RV32I pipeline; sits between fetch and execute.
- Accepts fetched instructions over a valid/ready handshake and classifies the opcode.
- Drives the immediate-type select, builds the sign-extended immediate, and registers decoded control fields into a 2-entry skid buffer toward execute.
- Provides single-cycle flush for branch redirect and a saturating stall-cycle counter.

---
 rtl/decode_ctrl.sv | 157 +++++++++++++++
 tb/tb_decode_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// RV32I decode stage: opcode classification, immediate build, 2-entry skid buffer toward execute.
// Optional build macro DECODE_ILLEGAL_EN adds out_illegal and forces ctrl to 0 on illegal encodings.
module decode_ctrl #(
   parameter int XLEN        = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic [XLEN-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_pc,
   output logic [31:0]            out_imm,
   output logic [2:0]             out_imm_sel,
   output logic [4:0]             out_rd,
   output logic [4:0]             out_rs1,
   output logic [4:0]             out_rs2,
   output logic [2:0]             out_funct3,
   output logic                   out_funct7b5,
   output logic [7:0]             out_ctrl,
`ifdef DECODE_ILLEGAL_EN
   output logic                   out_illegal,
`endif
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     imm;
      logic [2:0]      sel;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      f3;
      logic            f7b5;
      logic [7:0]      ctrl;
`ifdef DECODE_ILLEGAL_EN
      logic            ill;
`endif
   } entry_t;

   function automatic logic [31:0] imm_gen(input logic [31:0] i, input logic [2:0] sel);
      case (sel)
         3'd0:    imm_gen = {{20{i[31]}}, i[31:20]};
         3'd1:    imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2:    imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3:    imm_gen = {i[31:12], 12'b0};
         3'd4:    imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: imm_gen = 32'b0;
      endcase
   endfunction

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      sat_inc = (v == '1) ? v : v + STALL_CNT_W'(1);
   endfunction

   entry_t dec_p0;
   entry_t main_p1, skid_p1;
   logic   main_vld_p1, skid_vld_p1;
   logic   accept;

   // ---- stage 0: combinational decode of the incoming word
   // ctrl bit order: {reg_write, mem_read, mem_write, branch, jal, jalr, alu_src_imm, pc_rel}
   always_comb begin
      dec_p0      = '0;
      dec_p0.pc   = in_pc;
      dec_p0.rd   = in_instr[11:7];
      dec_p0.rs1  = in_instr[19:15];
      dec_p0.rs2  = in_instr[24:20];
      dec_p0.f3   = in_instr[14:12];
      dec_p0.f7b5 = in_instr[30];
      dec_p0.sel  = 3'd7;
      case (in_instr[6:0])
         7'b0110111: begin dec_p0.sel = 3'd3; dec_p0.ctrl = 8'h82; end
         7'b0010111: begin dec_p0.sel = 3'd3; dec_p0.ctrl = 8'h83; end
         7'b1101111: begin dec_p0.sel = 3'd4; dec_p0.ctrl = 8'h89; end
         7'b1100111: begin dec_p0.sel = 3'd0; dec_p0.ctrl = 8'h86; end
         7'b1100011: begin dec_p0.sel = 3'd2; dec_p0.ctrl = 8'h11; end
         7'b0000011: begin dec_p0.sel = 3'd0; dec_p0.ctrl = 8'hC2; end
         7'b0100011: begin dec_p0.sel = 3'd1; dec_p0.ctrl = 8'h22; end
         7'b0010011: begin dec_p0.sel = 3'd0; dec_p0.ctrl = 8'h82; end
         7'b0110011: begin
            dec_p0.ctrl = 8'h80;
`ifdef DECODE_ILLEGAL_EN
            dec_p0.ill  = (in_instr[31:25] != 7'b0000000) && (in_instr[31:25] != 7'b0100000);
`endif
         end
         7'b1110011: dec_p0.sel = 3'd0;
         default: begin
`ifdef DECODE_ILLEGAL_EN
            dec_p0.ill = 1'b1;   // also catches instr[1:0] != 2'b11: no listed opcode has that
`endif
         end
      endcase
`ifdef DECODE_ILLEGAL_EN
      if (dec_p0.ill) dec_p0.ctrl = 8'h00;
`endif
      dec_p0.imm = imm_gen(in_instr, dec_p0.sel);
   end

   assign in_ready = !skid_vld_p1;
   assign accept   = in_valid && in_ready;

   // ---- stage 1: main/skid registers; main drives the outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
         main_p1     <= '0;
      end else if (flush) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
      end else if (skid_vld_p1) begin
         if (out_ready) begin
            main_p1     <= skid_p1;
            skid_vld_p1 <= 1'b0;
         end
      end else if (accept) begin
         if (!main_vld_p1 || out_ready) begin
            main_p1     <= dec_p0;
            main_vld_p1 <= 1'b1;
         end else begin
            skid_vld_p1 <= 1'b1;
         end
      end else if (out_ready) begin
         main_vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && main_vld_p1 && !out_ready && !flush) skid_p1 <= dec_p0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         stall_cnt <= '0;
      else if (main_vld_p1 && !out_ready) stall_cnt <= sat_inc(stall_cnt);
   end

   assign out_valid    = main_vld_p1;
   assign out_pc       = main_p1.pc;
   assign out_imm      = main_p1.imm;
   assign out_imm_sel  = main_p1.sel;
   assign out_rd       = main_p1.rd;
   assign out_rs1      = main_p1.rs1;
   assign out_rs2      = main_p1.rs2;
   assign out_funct3   = main_p1.f3;
   assign out_funct7b5 = main_p1.f7b5;
   assign out_ctrl     = main_p1.ctrl;
`ifdef DECODE_ILLEGAL_EN
   assign out_illegal  = main_p1.ill;
`endif

endmodule

// File: tb/tb_decode_ctrl.sv
// Table-driven, scoreboarded bench for decode_ctrl; small stall counter width to reach saturation.
module tb_decode_ctrl;
   localparam int XLEN = 32;
   localparam int SW   = 4;
   localparam int NV   = 15;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  sel;
      logic [7:0]  ctrl;
      logic        ill;
   } rec_t;

   logic            clk = 1'b0;
   logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]     in_instr, out_imm;
   logic [XLEN-1:0] in_pc, out_pc;
   logic [2:0]      out_imm_sel, out_funct3;
   logic [4:0]      out_rd, out_rs1, out_rs2;
   logic            out_funct7b5;
   logic [7:0]      out_ctrl;
   logic [SW-1:0]   stall_cnt;
`ifdef DECODE_ILLEGAL_EN
   logic            out_illegal;
`endif

   decode_ctrl #(.XLEN(XLEN), .STALL_CNT_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
      .out_imm_sel(out_imm_sel), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_ctrl(out_ctrl),
`ifdef DECODE_ILLEGAL_EN
      .out_illegal(out_illegal),
`endif
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   rec_t          tbl [NV];
   rec_t          q [$];
   rec_t          idle;
   logic [SW-1:0] exp_stall;
   int            n_vec = 0;
   int            n_err = 0;

   function automatic rec_t mk(input logic [31:0] instr, input logic [31:0] imm,
                               input logic [2:0] sel, input logic [7:0] ctrl, input logic ill);
      rec_t r;
      r.instr = instr; r.pc = 32'h0; r.imm = imm; r.sel = sel; r.ctrl = ctrl; r.ill = ill;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, compare outputs to the model, advance the model across the edge.
   task automatic cycle(input logic v, input rec_t r, input logic ordy, input logic fl);
      int   old;
      rec_t e;
      in_valid = v; in_instr = r.instr; in_pc = r.pc; out_ready = ordy; flush = fl;
      #1;
      old = q.size();
      chk("out_valid", 32'(out_valid), 32'(old > 0));
      chk("in_ready", 32'(in_ready), 32'(old < 2));
      chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      if (old > 0) begin
         e = q[0];
         chk("pc", out_pc, e.pc);
         chk("imm", out_imm, e.imm);
         chk("imm_sel", 32'(out_imm_sel), 32'(e.sel));
         chk("ctrl", 32'(out_ctrl), 32'(e.ctrl));
         chk("rd", 32'(out_rd), 32'(e.instr[11:7]));
         chk("rs1", 32'(out_rs1), 32'(e.instr[19:15]));
         chk("rs2", 32'(out_rs2), 32'(e.instr[24:20]));
         chk("funct3", 32'(out_funct3), 32'(e.instr[14:12]));
         chk("funct7b5", 32'(out_funct7b5), 32'(e.instr[30]));
`ifdef DECODE_ILLEGAL_EN
         chk("illegal", 32'(out_illegal), 32'(e.ill));
`endif
      end
      if (old > 0 && !ordy && exp_stall != '1) exp_stall++;
      if (fl) q.delete();
      else begin
         if (old > 0 && ordy) void'(q.pop_front());
         if (v && old < 2) q.push_back(r);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic mid_reset();
      in_valid = 1'b0; flush = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      q.delete();
      exp_stall = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic rec_t at(input int i, input logic [31:0] pc);
      rec_t r;
      r = tbl[i];
      r.pc = pc;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rec_t a, b, c, d;
      int   idx;
      logic v, o;

      tbl[0]  = mk(32'h00A00093, 32'h0000000A, 3'd0, 8'h82, 1'b0); // addi x1,x0,10
      tbl[1]  = mk(32'hFFDFF0EF, 32'hFFFFFFFC, 3'd4, 8'h89, 1'b0); // jal x1,-4
      tbl[2]  = mk(32'hFE000CE3, 32'hFFFFFFF8, 3'd2, 8'h11, 1'b0); // beq x0,x0,-8
      tbl[3]  = mk(32'h0020A423, 32'h00000008, 3'd1, 8'h22, 1'b0); // sw x2,8(x1)
      tbl[4]  = mk(32'h123452B7, 32'h12345000, 3'd3, 8'h82, 1'b0); // lui x5,0x12345
      tbl[5]  = mk(32'h002081B3, 32'h00000000, 3'd7, 8'h80, 1'b0); // add x3,x1,x2
      tbl[6]  = mk(32'hFFFFF097, 32'hFFFFF000, 3'd3, 8'h83, 1'b0); // auipc x1,0xFFFFF
      tbl[7]  = mk(32'h00008067, 32'h00000000, 3'd0, 8'h86, 1'b0); // jalr x0,0(x1)
      tbl[8]  = mk(32'hFFC12283, 32'hFFFFFFFC, 3'd0, 8'hC2, 1'b0); // lw x5,-4(x2)
      tbl[9]  = mk(32'h00000073, 32'h00000000, 3'd0, 8'h00, 1'b0); // ecall
      tbl[10] = mk(32'h0000007F, 32'h00000000, 3'd7, 8'h00, 1'b1); // unlisted opcode
      tbl[11] = mk(32'hFE20AE23, 32'hFFFFFFFC, 3'd1, 8'h22, 1'b0); // sw x2,-4(x1)
      tbl[12] = mk(32'h402081B3, 32'h00000000, 3'd7, 8'h80, 1'b0); // sub x3,x1,x2
`ifdef DECODE_ILLEGAL_EN
      tbl[13] = mk(32'h022081B3, 32'h00000000, 3'd7, 8'h00, 1'b1); // funct7=0000001
`else
      tbl[13] = mk(32'h022081B3, 32'h00000000, 3'd7, 8'h80, 1'b0);
`endif
      tbl[14] = mk(32'h00000001, 32'h00000000, 3'd7, 8'h00, 1'b1); // instr[1:0]=01
      idle = mk(32'h0, 32'h0, 3'd0, 8'h0, 1'b0);

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = '0; exp_stall = '0;
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("reset_imm", out_imm, 32'd0);
      chk("reset_imm_sel", 32'(out_imm_sel), 32'd0);
      chk("reset_ctrl", 32'(out_ctrl), 32'd0);
      chk("reset_rd", 32'(out_rd), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // streaming, no backpressure
      for (int i = 0; i < NV; i++) cycle(1'b1, at(i, 32'h1000 + 32'(4 * i)), 1'b1, 1'b0);
      repeat (3) cycle(1'b0, idle, 1'b1, 1'b0);

      // random valid/ready
      idx = 0;
      for (int k = 0; k < 120; k++) begin
         v = 1'($urandom_range(0, 1));
         o = 1'($urandom_range(0, 1));
         a = at(idx % NV, 32'h2000 + 32'(4 * idx));
         if (v && q.size() < 2) begin
            cycle(v, a, o, 1'b0);
            idx++;
         end else begin
            cycle(v, a, o, 1'b0);
         end
      end
      repeat (3) cycle(1'b0, idle, 1'b1, 1'b0);

      // backpressure: A held, B to skid, C refused until space frees
      mid_reset();
      a = at(0, 32'h3000); b = at(1, 32'h3004); c = at(4, 32'h3008); d = at(3, 32'h300C);
      cycle(1'b1, a, 1'b0, 1'b0);
      cycle(1'b1, b, 1'b0, 1'b0);
      cycle(1'b1, c, 1'b0, 1'b0);
      cycle(1'b1, c, 1'b0, 1'b0);
      #1;
      chk("bp_stall_cnt", 32'(stall_cnt), 32'd3);
      chk("bp_head_pc", out_pc, 32'h3000);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      cycle(1'b1, c, 1'b1, 1'b0);
      cycle(1'b1, c, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);

      // flush while full with a same-cycle input
      cycle(1'b1, a, 1'b0, 1'b0);
      cycle(1'b1, b, 1'b0, 1'b0);
      cycle(1'b1, c, 1'b0, 1'b1);
      #1;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      cycle(1'b1, d, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);

      // stall counter saturation, untouched by draining
      mid_reset();
      cycle(1'b1, a, 1'b0, 1'b0);
      repeat (20) cycle(1'b0, idle, 1'b0, 1'b0);
      #1;
      chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);
      #1;
      chk("sat_hold", 32'(stall_cnt), 32'd15);

      // reset asserted mid-stall
      cycle(1'b1, a, 1'b0, 1'b0);
      cycle(1'b1, b, 1'b0, 1'b0);
      cycle(1'b0, idle, 1'b0, 1'b0);
      mid_reset();
      cycle(1'b0, idle, 1'b1, 1'b0);
      cycle(1'b0, idle, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
